// File: rtl/uart_infer_ctrl.sv
// Frame sequencer between the UART pair and the CNN core.
// It receives a frame of SYNC_BYTE, IMG_BYTES pixels and an 8-bit additive checksum.
// Pixels go to the image buffer. A good frame runs one inference and sends the digit
// followed by a newline. A bad checksum sends "E\n". An inter-byte timeout inside a
// frame drops the frame and sends nothing.
// Ports:
//   clk, reset (async, active-low)
//   rx_dv/rx_byte                       byte strobe from uart_rx
//   tx_dv/tx_byte/tx_busy               handshake with uart_tx
//   mem_we/mem_addr/mem_wdata           image buffer write port
//   cnn_start/cnn_done/cnn_digit        inference control
//   frame_ok/frame_err                  frame status pulses
module uart_infer_ctrl #(
    parameter int unsigned IMG_BYTES    = 784,
    parameter int unsigned ADDR_W       = 10,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cnn_start,
    input  logic              cnn_done,
    input  logic [3:0]        cnn_digit,
    output logic              frame_ok,
    output logic              frame_err
);

    localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE, RX_PIX, RX_CSUM, START, WAIT_DONE, TX_REQ, TX_WHI, TX_WLO
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              nl_q, nl_d;     // set while the trailing newline is in flight
    logic              tmo_hit;

    logic              tx_dv_d, mem_we_d, cnn_start_d, frame_ok_d, frame_err_d;
    logic [7:0]        tx_byte_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;

    // Last idle clock of the allowed inter-byte gap
    assign tmo_hit = (tmo_q == TMO_LAST);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            nl_q      <= 1'b0;
            tx_dv     <= 1'b0;
            tx_byte   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnn_start <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            nl_q      <= nl_d;
            tx_dv     <= tx_dv_d;
            tx_byte   <= tx_byte_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            cnn_start <= cnn_start_d;
            frame_ok  <= frame_ok_d;
            frame_err <= frame_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        csum_d      = csum_q;
        tmo_d       = tmo_q;
        nl_d        = nl_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        cnn_start_d = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_dv && (rx_byte == SYNC_BYTE)) begin
                    state_d = RX_PIX;
                    pix_d   = '0;
                    csum_d  = '0;
                    tmo_d   = '0;
                end
            end
            RX_PIX, RX_CSUM: begin
                if (rx_dv) begin
                    // An arriving byte always beats a coincident timeout
                    tmo_d = '0;
                    if (state_q == RX_PIX) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = pix_q;
                        mem_wdata_d = rx_byte;
                        csum_d      = csum_q + rx_byte;
                        if (pix_q == PIX_LAST) state_d = RX_CSUM;
                        else                   pix_d   = pix_q + ADDR_W'(1);
                    end else if (rx_byte == csum_q) begin
                        frame_ok_d = 1'b1;
                        state_d    = START;
                    end else begin
                        frame_err_d = 1'b1;
                        tx_byte_d   = 8'h45;
                        nl_d        = 1'b0;
                        state_d     = TX_REQ;
                    end
                end else if (tmo_hit) begin
                    frame_err_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            START: begin
                cnn_start_d = 1'b1;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cnn_done) begin
                    tx_byte_d = (cnn_digit <= 4'd9) ? (8'h30 + {4'h0, cnn_digit}) : 8'h3F;
                    nl_d      = 1'b0;
                    state_d   = TX_REQ;
                end
            end
            TX_REQ: begin
                if (!tx_busy) begin
                    tx_dv_d = 1'b1;
                    state_d = TX_WHI;
                end
            end
            TX_WHI: begin
                if (tx_busy) state_d = TX_WLO;
            end
            TX_WLO: begin
                if (!tx_busy) begin
                    if (!nl_q) begin
                        tx_byte_d = 8'h0A;
                        nl_d      = 1'b1;
                        state_d   = TX_REQ;
                    end else begin
                        nl_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
